// File: rtl/vx_dmem_lane_serializer.sv
// rtl/vx_dmem_lane_serializer.sv - serializes a warp dcache request onto one TileLink-UL port
//
// Takes one warp-wide dcache request (per-lane valid mask, shared tag) and
// issues the active lanes one A beat at a time, lowest lane first. D
// responses may return in any order. Once every lane has been answered, a
// single dcache response is returned if any lane was a load.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   core_req_*           warp request; per-lane valid/rw/byteen/addr/data, shared tag
//   core_req_ready       per-lane ready (all ones while IDLE)
//   core_rsp_*           warp response; tmask = load lanes, per-lane data, tag
//   tl_a_*               TileLink-UL A channel (one lane per beat, source = lane)
//   tl_d_*               TileLink-UL D channel (source = lane)
//   busy                 high in any state other than IDLE
//   err_unexpected       one-cycle pulse after a D beat that matches no outstanding lane
module vx_dmem_lane_serializer #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 30,
  parameter int TAG_W     = 10,
  parameter int SRC_W     = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        core_req_valid,
  input  logic [NUM_LANES-1:0]        core_req_rw,
  input  logic [NUM_LANES*4-1:0]      core_req_byteen,
  input  logic [NUM_LANES*ADDR_W-1:0] core_req_addr,
  input  logic [NUM_LANES*32-1:0]     core_req_data,
  input  logic [TAG_W-1:0]            core_req_tag,
  output logic [NUM_LANES-1:0]        core_req_ready,
  output logic                        core_rsp_valid,
  output logic [NUM_LANES-1:0]        core_rsp_tmask,
  output logic [NUM_LANES*32-1:0]     core_rsp_data,
  output logic [TAG_W-1:0]            core_rsp_tag,
  input  logic                        core_rsp_ready,
  output logic                        tl_a_valid,
  input  logic                        tl_a_ready,
  output logic [2:0]                  tl_a_opcode,
  output logic [3:0]                  tl_a_size,
  output logic [SRC_W-1:0]            tl_a_source,
  output logic [31:0]                 tl_a_address,
  output logic [3:0]                  tl_a_mask,
  output logic [31:0]                 tl_a_data,
  input  logic                        tl_d_valid,
  output logic                        tl_d_ready,
  input  logic [2:0]                  tl_d_opcode,
  input  logic [SRC_W-1:0]            tl_d_source,
  input  logic [31:0]                 tl_d_data,
  output logic                        busy,
  output logic                        err_unexpected
);

  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   pending_q, pending_d;
  logic [NUM_LANES-1:0]   outst_q, outst_d;
  logic [NUM_LANES-1:0]   read_q, read_d;
  logic [NUM_LANES-1:0]   got_q, got_d;
  logic [NUM_LANES-1:0]   rw_q;
  logic [TAG_W-1:0]       tag_q;
  logic [3:0]             byteen_q [NUM_LANES];
  logic [ADDR_W-1:0]      addr_q   [NUM_LANES];
  logic [31:0]            wdata_q  [NUM_LANES];
  logic [31:0]            rbuf_q   [NUM_LANES];
  logic                   err_q, err_d;
  logic                   rst_q;

  logic                   blocked;
  logic                   accept;
  logic [LANE_W-1:0]      cur;
  logic [LANE_W-1:0]      d_idx;
  logic                   d_fire;
  logic                   d_match;
  logic                   a_fire;

  // Outputs stay quiet while reset is asserted and for one cycle afterwards.
  assign blocked = reset | rst_q;

  always_comb begin
    cur = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) cur = LANE_W'(i);
    end
  end

  assign tl_a_size    = 4'd2;
  assign tl_a_source  = SRC_W'(cur);
  assign tl_a_address = 32'({addr_q[cur], 2'b00});
  assign tl_a_mask    = byteen_q[cur];
  assign tl_a_data    = wdata_q[cur];
  assign tl_a_opcode  = rw_q[cur] ? ((&byteen_q[cur]) ? 3'd0 : 3'd1) : 3'd4;

  assign d_idx   = tl_d_source[LANE_W-1:0];
  assign d_fire  = tl_d_valid & tl_d_ready;
  // Match against the registered outstanding mask: a D beat for a lane whose
  // A beat fires in the same cycle is treated as unmatched.
  assign d_match = d_fire && (tl_d_source < SRC_W'(NUM_LANES)) && outst_q[d_idx];
  assign a_fire  = tl_a_valid & tl_a_ready;

  assign busy           = (state_q != S_IDLE) && !blocked;
  assign err_unexpected = err_q;
  assign core_rsp_tmask = read_q;
  assign core_rsp_tag   = tag_q;

  always_comb begin
    core_rsp_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      core_rsp_data[l*32 +: 32] = got_q[l] ? rbuf_q[l] : 32'h0;
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    outst_d        = outst_q;
    read_d         = read_q;
    got_d          = got_q;
    err_d          = d_fire & ~d_match;
    accept         = 1'b0;
    core_req_ready = '0;
    core_rsp_valid = 1'b0;
    tl_a_valid     = 1'b0;
    tl_d_ready     = 1'b0;

    if (d_match) begin
      outst_d[d_idx] = 1'b0;
      if (tl_d_opcode == 3'd1) got_d[d_idx] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!blocked) begin
          core_req_ready = '1;
          if (|core_req_valid) begin
            accept    = 1'b1;
            pending_d = core_req_valid;
            read_d    = core_req_valid & ~core_req_rw;
            outst_d   = '0;
            got_d     = '0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tl_a_valid = !blocked;
        tl_d_ready = !blocked;
        if (a_fire) begin
          pending_d[cur] = 1'b0;
          outst_d[cur]   = 1'b1;
        end
        if (pending_d == '0) state_d = S_WAIT;
      end
      S_WAIT: begin
        tl_d_ready = !blocked;
        // Uses next-state masks so the exit can coincide with the last D fire.
        if (outst_d == '0 && pending_d == '0) begin
          state_d = (read_q != '0) ? S_RESP : S_IDLE;
        end
      end
      S_RESP: begin
        core_rsp_valid = !blocked;
        if (core_rsp_ready && !blocked) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      outst_q   <= '0;
      read_q    <= '0;
      got_q     <= '0;
      rw_q      <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
      rst_q     <= 1'b1;
      for (int l = 0; l < NUM_LANES; l++) begin
        byteen_q[l] <= '0;
        addr_q[l]   <= '0;
        wdata_q[l]  <= '0;
        rbuf_q[l]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      outst_q   <= outst_d;
      read_q    <= read_d;
      got_q     <= got_d;
      err_q     <= err_d;
      rst_q     <= 1'b0;
      if (accept) begin
        rw_q  <= core_req_rw;
        tag_q <= core_req_tag;
        for (int l = 0; l < NUM_LANES; l++) begin
          byteen_q[l] <= core_req_byteen[l*4 +: 4];
          addr_q[l]   <= core_req_addr[l*ADDR_W +: ADDR_W];
          wdata_q[l]  <= core_req_data[l*32 +: 32];
        end
      end
      if (d_match && tl_d_opcode == 3'd1) rbuf_q[d_idx] <= tl_d_data;
    end
  end

endmodule

// File: tb/tb_vx_dmem_lane_serializer.sv
// tb/tb_vx_dmem_lane_serializer.sv - bench for vx_dmem_lane_serializer
module tb_vx_dmem_lane_serializer;
  localparam int NL = 4;
  localparam int AW = 30;
  localparam int TW = 10;
  localparam int SW = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic [NL-1:0]   core_req_valid, core_req_rw, core_req_ready;
  logic [NL*4-1:0] core_req_byteen;
  logic [NL*AW-1:0] core_req_addr;
  logic [NL*32-1:0] core_req_data;
  logic [TW-1:0]   core_req_tag;
  logic            core_rsp_valid, core_rsp_ready;
  logic [NL-1:0]   core_rsp_tmask;
  logic [NL*32-1:0] core_rsp_data;
  logic [TW-1:0]   core_rsp_tag;
  logic            tl_a_valid, tl_a_ready;
  logic [2:0]      tl_a_opcode;
  logic [3:0]      tl_a_size, tl_a_mask;
  logic [SW-1:0]   tl_a_source;
  logic [31:0]     tl_a_address, tl_a_data;
  logic            tl_d_valid, tl_d_ready;
  logic [2:0]      tl_d_opcode;
  logic [SW-1:0]   tl_d_source;
  logic [31:0]     tl_d_data;
  logic            busy, err_unexpected;

  vx_dmem_lane_serializer #(.NUM_LANES(NL), .ADDR_W(AW), .TAG_W(TW), .SRC_W(SW)) dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask),
    .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_size(tl_a_size), .tl_a_source(tl_a_source), .tl_a_address(tl_a_address),
    .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_source(tl_d_source), .tl_d_data(tl_d_data),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  int n_run = 0;
  int n_fail = 0;

  // Observations collected by run_req
  int          a_src[$];
  logic [31:0] a_addr[$];
  logic [2:0]  a_op[$];
  logic [3:0]  a_mask[$];
  logic [31:0] a_dat[$];
  bit          rsp_seen;
  logic [NL-1:0] rsp_tmask;
  logic [NL*32-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [31:0] d_sent[NL];
  int          stab_err, err_pulses, rsp_ready_err, rsp_cycles;
  bit          timeout;

  function automatic logic [2:0] exp_op(input logic rw, input logic [3:0] be);
    return rw ? ((be == 4'hF) ? 3'd0 : 3'd1) : 3'd4;
  endfunction

  // Drives one request, plays the memory side and the response sink.
  // dmode: 0 in-order D, 2 random order, 3 reverse order after all A beats (data from dfix).
  task automatic run_req(input logic [NL-1:0] v, input logic [NL-1:0] rw,
                         input logic [NL*4-1:0] be, input logic [NL*AW-1:0] ad,
                         input logic [NL*32-1:0] dt, input logic [TW-1:0] tg,
                         input int amode, input int dmode,
                         input logic [NL*32-1:0] dfix, input int stall);
    int outs[$];
    int newl[$];
    int stall_left, nact, lane, idx;
    logic pv;
    logic [2:0] pop;
    logic [SW-1:0] psrc;
    logic [31:0] paddr, pdata;
    logic [3:0] pmask;
    a_src.delete(); a_addr.delete(); a_op.delete(); a_mask.delete(); a_dat.delete();
    rsp_seen = 0; stab_err = 0; err_pulses = 0; rsp_ready_err = 0; rsp_cycles = 0;
    timeout = 1; pv = 0; stall_left = stall; nact = $countones(v);
    pop = '0; psrc = '0; paddr = '0; pdata = '0; pmask = '0;
    for (int l = 0; l < NL; l++) d_sent[l] = '0;
    for (int w = 0; w < 20 && core_req_ready != 4'hF; w++) @(negedge clock);
    core_req_valid = v; core_req_rw = rw; core_req_byteen = be;
    core_req_addr = ad; core_req_data = dt; core_req_tag = tg;
    @(negedge clock);
    core_req_valid = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (!busy) begin
        timeout = 0;
        break;
      end
      if (err_unexpected) err_pulses++;
      if (pv) begin
        if (!tl_a_valid) stab_err++;
        else if ({tl_a_opcode, tl_a_source, tl_a_address, tl_a_mask, tl_a_data} !==
                 {pop, psrc, paddr, pmask, pdata}) stab_err++;
      end
      tl_a_ready = (amode == 0) ? 1'b1 : (amode == 1) ? (cyc % 2 == 1) : ($urandom % 2 == 1);
      if (tl_a_valid && tl_a_ready) begin
        a_src.push_back(int'(tl_a_source)); a_addr.push_back(tl_a_address);
        a_op.push_back(tl_a_opcode); a_mask.push_back(tl_a_mask); a_dat.push_back(tl_a_data);
        newl.push_back(int'(tl_a_source));
      end
      pv = tl_a_valid && !tl_a_ready;
      pop = tl_a_opcode; psrc = tl_a_source; paddr = tl_a_address; pmask = tl_a_mask; pdata = tl_a_data;
      tl_d_valid = 1'b0;
      if (tl_d_ready && outs.size() > 0) begin
        idx = -1;
        if (dmode == 0 && $urandom % 3 != 0) idx = 0;
        else if (dmode == 2 && $urandom % 3 != 0) idx = int'($urandom_range(outs.size() - 1, 0));
        else if (dmode == 3 && a_src.size() == nact && newl.size() == 0) idx = outs.size() - 1;
        if (idx >= 0) begin
          lane = outs[idx];
          outs.delete(idx);
          tl_d_valid = 1'b1;
          tl_d_source = SW'(lane);
          tl_d_opcode = rw[lane] ? 3'd0 : 3'd1;
          tl_d_data = (dmode == 3) ? dfix[lane*32 +: 32] : $urandom;
          d_sent[lane] = tl_d_data;
        end
      end
      foreach (newl[k]) outs.push_back(newl[k]);
      newl.delete();
      core_rsp_ready = 1'b0;
      if (core_rsp_valid) begin
        rsp_cycles++;
        if (!rsp_seen) begin
          rsp_seen = 1; rsp_tmask = core_rsp_tmask; rsp_data = core_rsp_data; rsp_tag = core_rsp_tag;
        end else if ({core_rsp_tmask, core_rsp_data, core_rsp_tag} !== {rsp_tmask, rsp_data, rsp_tag}) begin
          stab_err++;
        end
        if (core_req_ready !== '0) rsp_ready_err++;
        if (stall_left > 0) stall_left--;
        else core_rsp_ready = 1'b1;
      end
    end
    tl_a_ready = 1'b0; tl_d_valid = 1'b0; core_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_req_valid = '0; core_req_rw = '0; core_req_byteen = '0; core_req_addr = '0;
    core_req_data = '0; core_req_tag = '0; core_rsp_ready = 1'b0; tl_a_ready = 1'b0;
    tl_d_valid = 1'b0; tl_d_opcode = '0; tl_d_source = '0; tl_d_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_run++;
      if ({tl_a_valid, core_rsp_valid, busy, err_unexpected, core_req_ready, core_rsp_tmask} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got a_valid=%b rsp_valid=%b busy=%b err=%b req_ready=%b tmask=%b, expected all 0",
                 c, tl_a_valid, core_rsp_valid, busy, err_unexpected, core_req_ready, core_rsp_tmask);
      end
    end
    reset = 1'b0;
    #1;
    n_run++;
    if (core_req_ready !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_cycle: got req_ready=%b busy=%b, expected 0000/0", core_req_ready, busy);
    end
    @(negedge clock);
    n_run++;
    if (core_req_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got %b expected 1111", core_req_ready);
    end
  endtask

  task automatic test_load_pair();
    logic [NL*AW-1:0] ad;
    logic [NL*32-1:0] dfix;
    ad = '0; ad[0 +: AW] = 30'h100; ad[2*AW +: AW] = 30'h104;
    dfix = '0; dfix[2*32 +: 32] = 32'hBEEF; dfix[0 +: 32] = 32'hCAFE;
    run_req(4'b0101, 4'b0000, 16'hFFFF, ad, '0, 10'h2A, 0, 3, dfix, 0);
    n_run++;
    if (a_src.size() != 2) begin
      n_fail++;
      $display("FAIL load_pair_beats: got %0d expected 2", a_src.size());
    end else begin
      n_run++;
      if (a_src[0] != 0 || a_addr[0] !== 32'h400 || a_op[0] !== 3'd4 ||
          a_src[1] != 2 || a_addr[1] !== 32'h410 || a_op[1] !== 3'd4) begin
        n_fail++;
        $display("FAIL load_pair_a: got src %0d/%0d addr %h/%h op %0d/%0d expected 0/2 400/410 4/4",
                 a_src[0], a_src[1], a_addr[0], a_addr[1], a_op[0], a_op[1]);
      end
    end
    n_run++;
    if (!rsp_seen || rsp_tmask !== 4'b0101 || rsp_tag !== 10'h2A ||
        rsp_data[2*32 +: 32] !== 32'hBEEF || rsp_data[0 +: 32] !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL load_pair_rsp: got seen=%0d tmask=%b tag=%h d2=%h d0=%h expected 1 0101 02a 0000beef 0000cafe",
               rsp_seen, rsp_tmask, rsp_tag, rsp_data[2*32 +: 32], rsp_data[0 +: 32]);
    end
  endtask

  task automatic test_store_all();
    run_req(4'b1111, 4'b1111, 16'hFF3F, {4{30'h3FF0}}, {32'h44, 32'h33, 32'h22, 32'h11},
            10'h5, 0, 0, '0, 0);
    n_run++;
    if (a_op.size() != 4) begin
      n_fail++;
      $display("FAIL store_all_beats: got %0d expected 4", a_op.size());
    end else begin
      n_run++;
      if ({a_op[0], a_op[1], a_op[2], a_op[3]} !== {3'd0, 3'd1, 3'd0, 3'd0} ||
          a_mask[1] !== 4'b0011 || a_dat[1] !== 32'h22) begin
        n_fail++;
        $display("FAIL store_all_ops: got %0d %0d %0d %0d mask1=%b dat1=%h expected 0 1 0 0 0011 00000022",
                 a_op[0], a_op[1], a_op[2], a_op[3], a_mask[1], a_dat[1]);
      end
    end
    n_run++;
    if (rsp_seen || timeout || core_req_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL store_all_end: got rsp_seen=%0d timeout=%0d req_ready=%b expected 0 0 1111",
               rsp_seen, timeout, core_req_ready);
    end
  endtask

  task automatic test_a_stall();
    run_req(4'b1111, 4'b0000, 16'hFFFF, {30'h40, 30'h30, 30'h20, 30'h10}, '0, 10'h77, 1, 0, '0, 0);
    n_run++;
    if (stab_err != 0 || a_src.size() != 4) begin
      n_fail++;
      $display("FAIL a_stall: got stab_err=%0d fires=%0d expected 0 4", stab_err, a_src.size());
    end
    n_run++;
    if (!rsp_seen || rsp_tmask !== 4'b1111 ||
        rsp_data !== {d_sent[3], d_sent[2], d_sent[1], d_sent[0]}) begin
      n_fail++;
      $display("FAIL a_stall_rsp: got seen=%0d tmask=%b data=%h expected 1 1111 %h",
               rsp_seen, rsp_tmask, rsp_data, {d_sent[3], d_sent[2], d_sent[1], d_sent[0]});
    end
  endtask

  task automatic test_rsp_stall();
    run_req(4'b1010, 4'b0000, 16'hFFFF, {30'h9, 30'h8, 30'h7, 30'h6}, '0, 10'h3C3, 0, 2, '0, 5);
    n_run++;
    if (stab_err != 0 || rsp_ready_err != 0 || rsp_cycles != 6) begin
      n_fail++;
      $display("FAIL rsp_stall: got stab_err=%0d req_ready_err=%0d rsp_cycles=%0d expected 0 0 6",
               stab_err, rsp_ready_err, rsp_cycles);
    end
    n_run++;
    if (rsp_tmask !== 4'b1010 || rsp_tag !== 10'h3C3 || rsp_data[3*32 +: 32] !== d_sent[3] ||
        rsp_data[1*32 +: 32] !== d_sent[1]) begin
      n_fail++;
      $display("FAIL rsp_stall_fields: got tmask=%b tag=%h d3=%h d1=%h expected 1010 3c3 %h %h",
               rsp_tmask, rsp_tag, rsp_data[3*32 +: 32], rsp_data[1*32 +: 32], d_sent[3], d_sent[1]);
    end
  endtask

  task automatic test_spurious();
    core_req_valid = 4'b0001; core_req_rw = '0; core_req_byteen = 16'h000F;
    core_req_addr = '0; core_req_addr[0 +: AW] = 30'h55; core_req_tag = 10'h11;
    @(negedge clock);
    core_req_valid = '0;
    n_run++;
    if (tl_a_valid !== 1'b1 || tl_a_source !== '0 || tl_a_address !== 32'h154) begin
      n_fail++;
      $display("FAIL spurious_a: got valid=%b src=%0d addr=%h expected 1 0 00000154",
               tl_a_valid, tl_a_source, tl_a_address);
    end
    tl_a_ready = 1'b1;
    @(negedge clock);
    tl_a_ready = 1'b0;
    tl_d_valid = 1'b1; tl_d_source = 10'd3; tl_d_opcode = 3'd1; tl_d_data = 32'hDEAD;
    @(negedge clock);
    tl_d_valid = 1'b0;
    n_run++;
    if (err_unexpected !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_err_pulse: got %b expected 1", err_unexpected);
    end
    tl_d_valid = 1'b1; tl_d_source = 10'd0; tl_d_opcode = 3'd1; tl_d_data = 32'h12345678;
    @(negedge clock);
    tl_d_valid = 1'b0;
    n_run++;
    if (err_unexpected !== 1'b0 || core_rsp_valid !== 1'b1 || core_rsp_tmask !== 4'b0001 ||
        core_rsp_data[0 +: 32] !== 32'h12345678 || core_rsp_tag !== 10'h11) begin
      n_fail++;
      $display("FAIL spurious_rsp: got err=%b valid=%b tmask=%b d0=%h tag=%h expected 0 1 0001 12345678 011",
               err_unexpected, core_rsp_valid, core_rsp_tmask, core_rsp_data[0 +: 32], core_rsp_tag);
    end
    core_rsp_ready = 1'b1;
    @(negedge clock);
    core_rsp_ready = 1'b0;
    n_run++;
    if (busy !== 1'b0 || err_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_end: got busy=%b err=%b expected 0 0", busy, err_unexpected);
    end
  endtask

  task automatic test_random();
    logic [NL-1:0] v, rw;
    logic [NL*4-1:0] be;
    logic [NL*AW-1:0] ad;
    logic [NL*32-1:0] dt;
    logic [TW-1:0] tg;
    int k;
    for (int it = 0; it < 20; it++) begin
      v = NL'($urandom_range(15, 1));
      rw = NL'($urandom);
      for (int l = 0; l < NL; l++) begin
        be[l*4 +: 4] = ($urandom % 2 == 1) ? 4'hF : 4'($urandom);
        ad[l*AW +: AW] = AW'($urandom);
        dt[l*32 +: 32] = $urandom;
      end
      tg = TW'($urandom);
      run_req(v, rw, be, ad, dt, tg, int'($urandom % 3), ($urandom % 2 == 1) ? 2 : 0, '0,
              int'($urandom % 4));
      n_run++;
      if (a_src.size() != $countones(v) || timeout || stab_err != 0 || err_pulses != 0) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got beats=%0d timeout=%0d stab=%0d err=%0d expected %0d 0 0 0",
                 it, a_src.size(), timeout, stab_err, err_pulses, $countones(v));
      end else begin
        k = 0;
        for (int l = 0; l < NL; l++) begin
          if (v[l]) begin
            n_run++;
            if (a_src[k] != l || a_addr[k] !== {ad[l*AW +: AW], 2'b00} ||
                a_op[k] !== exp_op(rw[l], be[l*4 +: 4]) || a_mask[k] !== be[l*4 +: 4] ||
                (rw[l] && a_dat[k] !== dt[l*32 +: 32])) begin
              n_fail++;
              $display("FAIL rand%0d_beat%0d: got src=%0d addr=%h op=%0d mask=%b data=%h expected %0d %h %0d %b %h",
                       it, k, a_src[k], a_addr[k], a_op[k], a_mask[k], a_dat[k], l,
                       {ad[l*AW +: AW], 2'b00}, exp_op(rw[l], be[l*4 +: 4]), be[l*4 +: 4], dt[l*32 +: 32]);
            end
            k++;
          end
        end
      end
      n_run++;
      if (rsp_seen != ((v & ~rw) != '0)) begin
        n_fail++;
        $display("FAIL rand%0d_rsp_present: got %0d expected %0d", it, rsp_seen, ((v & ~rw) != '0));
      end else if (rsp_seen) begin
        n_run++;
        if (rsp_tmask !== (v & ~rw) || rsp_tag !== tg) begin
          n_fail++;
          $display("FAIL rand%0d_rsp_hdr: got tmask=%b tag=%h expected %b %h", it, rsp_tmask, rsp_tag, v & ~rw, tg);
        end
        for (int l = 0; l < NL; l++) begin
          if (v[l] && !rw[l]) begin
            n_run++;
            if (rsp_data[l*32 +: 32] !== d_sent[l]) begin
              n_fail++;
              $display("FAIL rand%0d_rsp_data%0d: got %h expected %h", it, l, rsp_data[l*32 +: 32], d_sent[l]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_pair();
    test_store_all();
    test_a_stall();
    test_rsp_stall();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_dmem_lane_serializer.md
Name: vx_dmem_lane_serializer

Overview:
- Shares one TileLink-UL data-memory port among the NUM_LANES lanes of a Vortex dcache request.
- Accepts one warp-wide request (per-lane valid mask, shared tag) and issues the active lanes one A beat at a time, lowest lane first.
- Collects out-of-order D responses and returns a single dcache response with a read tmask.
- Sits between VX_pipeline's dcache ports and a single dmem TL port in the core wrapper.

Parameters:
- NUM_LANES, 4, lanes per warp request; power of 2, ≥2.
- ADDR_W, 30, word address width; byte address is {addr, 2'b00}.
- TAG_W, 10, core request/response tag width.
- SRC_W, 10, TL source width; must be ≥ log2(NUM_LANES).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- core_req_valid  in  NUM_LANES  per-lane request valid
- core_req_rw  in  NUM_LANES  1 = store
- core_req_byteen  in  NUM_LANES*4  per-lane byte enables
- core_req_addr  in  NUM_LANES*ADDR_W  per-lane word address
- core_req_data  in  NUM_LANES*32  per-lane store data
- core_req_tag  in  TAG_W  shared tag
- core_req_ready  out  NUM_LANES  per-lane ready
- core_rsp_valid  out  1  response valid
- core_rsp_tmask  out  NUM_LANES  lanes carrying load data
- core_rsp_data  out  NUM_LANES*32  per-lane load data
- core_rsp_tag  out  TAG_W  tag of the completed request
- core_rsp_ready  in  1  response accepted
- tl_a_valid/tl_a_ready  out/in  1  A-channel handshake
- tl_a_opcode  out  3  0 PutFull, 1 PutPartial, 4 Get
- tl_a_size  out  4  constant 2
- tl_a_source  out  SRC_W  lane index, zero-extended
- tl_a_address  out  32  byte address
- tl_a_mask  out  4  byte enables
- tl_a_data  out  32  store data
- tl_d_valid/tl_d_ready  in/out  1  D-channel handshake
- tl_d_opcode  in  3  0 AccessAck, 1 AccessAckData
- tl_d_source  in  SRC_W  lane index
- tl_d_data  in  32  load data
- busy  out  1  high in any state other than IDLE
- err_unexpected  out  1  one-cycle pulse on an unmatched D beat

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (sync): state = IDLE; the pending, outstanding, read and got masks clear.
- Outputs while reset is high or in the cycle after: tl_a_valid = 0, core_rsp_valid = 0, busy = 0, err_unexpected = 0, core_req_ready = 0.
- Reset mid-operation abandons all in-flight lanes. Late D beats after reset are ignored and pulse err_unexpected.

IDLE:
- core_req_ready = all ones.
- On |core_req_valid, latch the request:
  - pending = valid
  - read = valid & ~rw
  - rw, byteen, addr, data, tag
- Go to ISSUE.

ISSUE:
- cur = lowest set bit of pending.
- tl_a_valid = 1 with that lane's fields.
- opcode = rw ? (&byteen ? 0 : 1) : 4.
- On A fire: clear pending[cur] and set outstanding[cur].
- At most one A beat per cycle; the first beat is presented the cycle after acceptance.
- When pending becomes empty, go to WAIT.

D channel:
- tl_d_ready = 1 in ISSUE and WAIT, 0 otherwise.
- On a D fire with outstanding[source] = 1:
  - clear outstanding[source]
  - if opcode = 1, store tl_d_data into the lane buffer and set got[source]
- A D fire with source ≥ NUM_LANES or outstanding[source] = 0 is dropped and pulses err_unexpected the next cycle.
- An A fire and a D fire for the same lane in the same cycle: the D fire is unmatched (outstanding is set only after the A fire).

WAIT:
- Leave when outstanding = 0 and pending = 0.
  - If read ≠ 0, go to RESP.
  - Otherwise go to IDLE; stores-only requests produce no response.
- The transition may occur in the same cycle as the last D fire.

RESP:
- core_rsp_valid = 1, core_rsp_tmask = read, data = lane buffer, tag = latched tag.
- Outputs are held stable until core_rsp_ready.
- Data of non-tmask lanes is don't-care.
- On ready, go to IDLE.
- A new request is accepted no earlier than the cycle after returning to IDLE.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0; core_req_ready = 4'b1111 from the first IDLE cycle after release.
- Loads on lanes {0,2}, addr 0x100/0x104, tag 0x2A, a_ready = 1, D returns source 2 then 0 with data 0xBEEF/0xCAFE → A beats: source 0 at 0x400, then source 2 at 0x410, opcode 4; rsp tmask = 4'b0101, data[2] = 0xBEEF, data[0] = 0xCAFE, tag = 0x2A.
- Stores on all lanes, lane 1 byteen = 4'b0011, others 4'b1111 → opcodes 0,1,0,0; four AccessAcks; no core_rsp_valid; busy falls; IDLE.
- a_ready toggled 0/1 every cycle on a 4-lane load → fields stay stable while stalled; exactly 4 A fires.
- core_rsp_ready held low 5 cycles in RESP → rsp fields constant; core_req_ready = 0 throughout.
- Spurious D beat with source 3 while only lane 0 is outstanding → err_unexpected pulses once; the lane 0 response still completes correctly.
